// File: rtl/maze_pkg.sv
// Shared definitions for the maze path checker and the rat-in-maze solver:
// direction encoding, error codes and the checker state encoding.
package maze_pkg;

    localparam int unsigned DIR_W = 2;
    localparam int unsigned ERR_W = 3;

    localparam logic [DIR_W-1:0] DIR_UP    = 2'b00;
    localparam logic [DIR_W-1:0] DIR_RIGHT = 2'b01;
    localparam logic [DIR_W-1:0] DIR_LEFT  = 2'b10;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 2'b11;

    localparam logic [ERR_W-1:0] ERR_NONE     = 3'd0;
    localparam logic [ERR_W-1:0] ERR_OOB      = 3'd1;
    localparam logic [ERR_W-1:0] ERR_WALL     = 3'd2;
    localparam logic [ERR_W-1:0] ERR_OFF_GOAL = 3'd3;
    localparam logic [ERR_W-1:0] ERR_PROTO    = 3'd4;
    localparam logic [ERR_W-1:0] ERR_START    = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHK0      = 3'd1,
        ST_WAIT0     = 3'd2,
        ST_WAIT_MOVE = 3'd3,
        ST_FETCH     = 3'd4,
        ST_EVAL      = 3'd5,
        ST_DONE      = 3'd6
    } state_e;

endpackage

// File: rtl/maze_step.sv
// One grid step: (row, col, dir) -> neighbouring cell plus an out-of-bounds flag.
// Purely combinational so the solver can share it.
module maze_step
    import maze_pkg::*;
#(
    parameter  int unsigned N  = 16,
    localparam int unsigned AW = $clog2(N)
) (
    input  logic [AW-1:0]    row,
    input  logic [AW-1:0]    col,
    input  logic [DIR_W-1:0] dir,
    output logic [AW-1:0]    next_row_c,
    output logic [AW-1:0]    next_col_c,
    output logic             oob_c
);

    always_comb begin
        next_row_c = row;
        next_col_c = col;
        oob_c      = 1'b0;
        case (dir)
            DIR_UP: begin
                oob_c      = (row == '0);
                next_row_c = row - AW'(1);
            end
            DIR_RIGHT: begin
                oob_c      = (col == AW'(N - 1));
                next_col_c = col + AW'(1);
            end
            DIR_LEFT: begin
                oob_c      = (col == '0);
                next_col_c = col - AW'(1);
            end
            default: begin
                oob_c      = (row == AW'(N - 1));
                next_row_c = row + AW'(1);
            end
        endcase
    end

endmodule

// File: rtl/maze_path_checker.sv
// Follows the solver's replayed path from (0,0) through the shared maze memory,
// checking every step and reporting pass/fail with the number of legal moves.
module maze_path_checker
    import maze_pkg::*;
#(
    parameter  int unsigned N     = 16,
    parameter  int unsigned CNT_W = 9,
    localparam int unsigned AW    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             move,
    input  logic [DIR_W-1:0] dir,
    input  logic             path_end,
    output logic             mem_rd,
    output logic [AW-1:0]    mem_addr,
    input  logic [N-1:0]     mem_data,
    output logic             ready,
    output logic             done,
    output logic             fail,
    output logic [ERR_W-1:0] err_code,
    output logic [CNT_W-1:0] steps
);

    state_e           state_q, state_d;
    logic [AW-1:0]    row_q, row_d, col_q, col_d;
    logic [AW-1:0]    cand_row_q, cand_row_d, cand_col_q, cand_col_d;
    logic             proto_q, proto_d;
    logic [AW-1:0]    mem_addr_d;
    logic [ERR_W-1:0] err_d;
    logic [CNT_W-1:0] steps_d;

    logic [AW-1:0]    next_row_c, next_col_c;
    logic             oob_c;
    logic             at_goal_c;

    maze_step #(.N(N)) u_step (
        .row        (row_q),
        .col        (col_q),
        .dir        (dir),
        .next_row_c (next_row_c),
        .next_col_c (next_col_c),
        .oob_c      (oob_c)
    );

    assign at_goal_c = (row_q == AW'(N - 1)) && (col_q == AW'(N - 1));

    // Next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        cand_row_d = cand_row_q;
        cand_col_d = cand_col_q;
        proto_d    = proto_q;
        mem_addr_d = mem_addr;
        err_d      = err_code;
        steps_d    = steps;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_CHK0;
                    err_d      = ERR_NONE;
                    steps_d    = '0;
                    row_d      = '0;
                    col_d      = '0;
                    proto_d    = 1'b0;
                    mem_addr_d = '0;
                end
            end
            ST_CHK0: begin
                if (move || path_end) begin
                    state_d = ST_DONE;
                    err_d   = ERR_PROTO;
                end else begin
                    state_d = ST_WAIT0;
                end
            end
            ST_WAIT0: begin
                if (mem_data[0]) begin
                    state_d = ST_DONE;
                    err_d   = ERR_START;
                end else if (move || path_end) begin
                    state_d = ST_DONE;
                    err_d   = ERR_PROTO;
                end else begin
                    state_d = ST_WAIT_MOVE;
                end
            end
            ST_WAIT_MOVE: begin
                if (move) begin
                    if (oob_c) begin
                        state_d = ST_DONE;
                        err_d   = ERR_OOB;
                    end else begin
                        state_d    = ST_FETCH;
                        cand_row_d = next_row_c;
                        cand_col_d = next_col_c;
                        mem_addr_d = next_row_c;
                        proto_d    = path_end;
                    end
                end else if (path_end) begin
                    state_d = ST_DONE;
                    err_d   = at_goal_c ? ERR_NONE : ERR_OFF_GOAL;
                end
            end
            ST_FETCH: begin
                if (move || path_end) begin
                    state_d = ST_DONE;
                    err_d   = ERR_PROTO;
                end else begin
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (mem_data[cand_col_q]) begin
                    state_d = ST_DONE;
                    err_d   = ERR_WALL;
                end else begin
                    row_d   = cand_row_q;
                    col_d   = cand_col_q;
                    steps_d = (steps == {CNT_W{1'b1}}) ? steps : steps + CNT_W'(1);
                    // A path_end that rode along with this move is still a violation.
                    if (proto_q || move || path_end) begin
                        state_d = ST_DONE;
                        err_d   = ERR_PROTO;
                    end else begin
                        state_d = ST_WAIT_MOVE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            cand_row_q <= '0;
            cand_col_q <= '0;
            proto_q    <= 1'b0;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            ready      <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            err_code   <= ERR_NONE;
            steps      <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            cand_row_q <= cand_row_d;
            cand_col_q <= cand_col_d;
            proto_q    <= proto_d;
            mem_addr   <= mem_addr_d;
            mem_rd     <= (state_d == ST_CHK0) || (state_d == ST_FETCH);
            ready      <= (state_d == ST_WAIT_MOVE);
            done       <= (state_d == ST_DONE);
            fail       <= (state_d == ST_DONE) && (err_d != ERR_NONE);
            err_code   <= err_d;
            steps      <= steps_d;
        end
    end

endmodule

// File: tb/tb_maze_path_checker.sv
// Scoreboard bench for maze_path_checker on a 4x4 maze: a path-walking reference
// model predicts each check's outcome, a monitor compares when done rises.
`timescale 1ns/1ps
module tb_maze_path_checker;
    import maze_pkg::*;

    localparam int unsigned N     = 4;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned AW    = 2;
    localparam int          NI    = 4;
    localparam int          SAT   = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             move;
    logic [1:0]       dir;
    logic             path_end;
    logic             mem_rd;
    logic [AW-1:0]    mem_addr;
    logic [N-1:0]     mem_data;
    logic             ready;
    logic             done;
    logic             fail;
    logic [2:0]       err_code;
    logic [CNT_W-1:0] steps;

    always #5 clk = ~clk;

    maze_path_checker #(.N(N), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .move     (move),
        .dir      (dir),
        .path_end (path_end),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .ready    (ready),
        .done     (done),
        .fail     (fail),
        .err_code (err_code),
        .steps    (steps)
    );

    // Maze memory: row data valid the cycle after a read request.
    logic [N-1:0] maze [N];
    always @(posedge clk) if (mem_rd) mem_data <= maze[mem_addr];

    typedef struct {
        int fail;
        int err;
        int steps;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] mv[$];
    int         total = 0;
    int         bad = 0;
    int         mem_rd_cnt = 0;
    int         last_lat = 0;
    logic       done_prev = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each completed check against the oldest prediction.
    always @(negedge clk) begin
        if (mem_rd) mem_rd_cnt++;
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("fail", int'(fail), e.fail);
                check("err_code", int'(err_code), e.err);
                check("steps", int'(steps), e.steps);
            end
        end
        done_prev = done;
    end

    // Reference: walk the path over the grid with plain integer arithmetic.
    function automatic exp_t model(input int proto_idx);
        exp_t e;
        int r, c, nr, nc, st;
        bit stop;
        r = 0; c = 0; st = 0; stop = 0; e.err = 0;
        if (maze[0][0]) begin
            e.err = 5;
            stop  = 1;
        end
        foreach (mv[i]) begin
            if (!stop) begin
                nr = r; nc = c;
                case (mv[i])
                    2'd0: nr = r - 1;
                    2'd1: nc = c + 1;
                    2'd2: nc = c - 1;
                    default: nr = r + 1;
                endcase
                if (nr < 0 || nr >= NI || nc < 0 || nc >= NI) begin
                    e.err = 1; stop = 1;
                end else if (i == proto_idx) begin
                    e.err = 4; stop = 1;
                end else if (maze[nr][nc]) begin
                    e.err = 2; stop = 1;
                end else begin
                    r = nr; c = nc;
                    if (st < SAT) st++;
                end
            end
        end
        if (!stop && !(r == NI - 1 && c == NI - 1)) e.err = 3;
        e.steps = st;
        e.fail  = (e.err != 0) ? 1 : 0;
        return e;
    endfunction

    task automatic wait_rdy_or_done();
        int n;
        n = 0;
        while (!ready && !done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!ready && !done) check("ready_timeout", 0, 1);
    endtask

    task automatic run_scn(input int proto_idx);
        exp_t e;
        int   lat;
        int   n;
        e = model(proto_idx);
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        foreach (mv[i]) begin
            wait_rdy_or_done();
            if (done || !ready) break;
            dir  = mv[i];
            move = 1'b1;
            @(negedge clk);
            if (i == proto_idx) begin
                move = 1'b1;
                @(negedge clk);
            end
            move = 1'b0;
            lat  = (i == proto_idx) ? 2 : 1;
            while (!ready && !done && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            last_lat = lat;
            if (ready && i != proto_idx) check("step_latency", lat, 3);
        end
        wait_rdy_or_done();
        if (!done && ready) begin
            path_end = 1'b1;
            @(negedge clk);
            path_end = 1'b0;
        end
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            check("done_timeout", 0, 1);
            exp_q.delete();
        end
        // Strobes after completion must leave the result untouched.
        dir = 2'd1; move = 1'b1; path_end = 1'b1;
        @(negedge clk);
        move = 1'b0; path_end = 1'b0;
        @(negedge clk);
        check("done_hold", int'(done), 1);
        check("err_hold", int'(err_code), e.err);
    endtask

    task automatic open_maze();
        for (int i = 0; i < NI; i++) maze[i] = '0;
    endtask

    task automatic set_moves(input string s);
        mv.delete();
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "U": mv.push_back(2'd0);
                "R": mv.push_back(2'd1);
                "L": mv.push_back(2'd2);
                default: mv.push_back(2'd3);
            endcase
        end
    endtask

    initial begin
        int base;
        int len;
        int pidx;
        rst = 1'b1; start = 1'b0; move = 1'b0; path_end = 1'b0; dir = 2'd0;
        open_maze();
        repeat (2) @(negedge clk);
        check("rst_ready", int'(ready), 0);
        check("rst_done", int'(done), 0);
        check("rst_fail", int'(fail), 0);
        check("rst_mem_rd", int'(mem_rd), 0);
        check("rst_err", int'(err_code), 0);
        check("rst_steps", int'(steps), 0);
        rst = 1'b0;

        open_maze(); set_moves("RRRDDD"); run_scn(-1);

        open_maze(); maze[0] = 4'b0010; set_moves("RD"); run_scn(-1);

        open_maze(); set_moves("U");
        base = mem_rd_cnt;
        run_scn(-1);
        check("oob_latency", last_lat, 1);
        check("oob_mem_rd_count", mem_rd_cnt - base, 1);

        open_maze(); set_moves("RD"); run_scn(-1);
        open_maze(); set_moves("RRD"); run_scn(1);
        open_maze(); maze[0] = 4'b0001; set_moves("RR"); run_scn(-1);
        open_maze(); set_moves("RLRLRLRLRRRDDD"); run_scn(-1);
        open_maze(); set_moves(""); run_scn(-1);

        // Abort mid-step with reset, then replay cleanly.
        open_maze();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_rdy_or_done();
        dir = 2'd1; move = 1'b1;
        @(negedge clk); move = 1'b0;
        check("fetch_mem_rd", int'(mem_rd), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", int'(ready), 0);
        check("abort_done", int'(done), 0);
        check("abort_fail", int'(fail), 0);
        check("abort_mem_rd", int'(mem_rd), 0);
        check("abort_err", int'(err_code), 0);
        check("abort_steps", int'(steps), 0);
        set_moves("DDDRRR"); run_scn(-1);

        // Random mazes and paths.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NI; i++) maze[i] = 4'($urandom & $urandom);
            if ($urandom_range(0, 9) != 0) maze[0][0] = 1'b0;
            len = $urandom_range(0, 10);
            mv.delete();
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) mv.push_back(2'($urandom_range(0, 3)));
                else mv.push_back(($urandom_range(0, 1) == 0) ? 2'd1 : 2'd3);
            end
            pidx = (len > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(0, len - 1) : -1;
            run_scn(pidx);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
